// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Destination-domain reset sequencer. Stretches a synchronized
//               reset request into a minimum-length reset, then releases the
//               rst_out bits one at a time (bit 0 first) with a fixed gap.
//               Provides busy/done status and a saturating request counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_in,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  event_cnt
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W   = (STAGE_GAP > 1)   ? $clog2(STAGE_GAP)   : 1;
  localparam int STAGE_W = (NUM_STAGES > 1)  ? $clog2(NUM_STAGES)  : 1;

  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0]    STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   req_q;
  logic                   rise;
  logic [HOLD_W-1:0]      hold_q;
  logic [GAP_W-1:0]       gap_q;
  logic [STAGE_W-1:0]     stage_q;
  logic [NUM_STAGES-1:0]  rst_out_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;

  // req_q resets high so a request already asserted at reset release is
  // not mistaken for a new event.
  assign rise = req_in & ~req_q;

  // Next value of the event counter: saturating increment on each rise.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Request edge detector and event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      req_q <= req_in;
      cnt_q <= cnt_d;
    end
  end

  // Sequencer FSM: reset comes up in HOLD so power-on runs a full sequence.
  // rst_out is a thermometer code; each release shifts a zero in at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      rst_out_q <= ALL_ONES;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= HOLD;
            rst_out_q <= ALL_ONES;
            busy_q    <= 1'b1;
            hold_q    <= '0;
          end
        end
        HOLD: begin
          // An active request pins the hold counter, extending the reset.
          if (req_in) begin
            hold_q <= '0;
          end else if (hold_q == HOLD_LAST) begin
            state_q <= RELEASE;
            hold_q  <= '0;
            gap_q   <= '0;
            stage_q <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RELEASE: begin
          // A new request aborts the release and wins over a stage clear.
          if (rise) begin
            state_q   <= HOLD;
            rst_out_q <= ALL_ONES;
            hold_q    <= '0;
            gap_q     <= '0;
            stage_q   <= '0;
          end else if (gap_q == GAP_LAST) begin
            gap_q     <= '0;
            rst_out_q <= rst_out_q << 1;
            if (stage_q == STAGE_LAST) begin
              stage_q <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q   <= HOLD;
          rst_out_q <= ALL_ONES;
          busy_q    <= 1'b1;
          hold_q    <= '0;
          gap_q     <= '0;
          stage_q   <= '0;
        end
      endcase
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign event_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer. Expected outputs are
//               derived from the release timing formulas, queued with the
//               cycle they are due, and compared on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 8;

  logic       clk;
  logic       rst_n;
  logic       req_in;
  logic       req2;
  logic [3:0] rst_out;
  logic       busy;
  logic       done;
  logic [7:0] event_cnt;
  logic [3:0] rst_out2;
  logic       busy2;
  logic       done2;
  logic [1:0] event_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_seen = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] r;
    logic       b;
    logic       d;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  reset_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .rst_out   (rst_out),
    .busy      (busy),
    .done      (done),
    .event_cnt (event_cnt)
  );

  reset_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req2),
    .rst_out   (rst_out2),
    .busy      (busy2),
    .done      (done2),
    .event_cnt (event_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: compare every entry due at this cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      sb_e = sb.pop_front();
      checks++;
      assert (sb_e.cyc == cyc &&
              {rst_out, busy, done, event_cnt} === {sb_e.r, sb_e.b, sb_e.d, sb_e.c})
      else begin
        errors++;
        $error("FAIL %s cyc=%0d due=%0d observed rst=%h busy=%b done=%b cnt=%0d expected rst=%h busy=%b done=%b cnt=%0d",
               sb_e.tag, cyc, sb_e.cyc, rst_out, busy, done, event_cnt,
               sb_e.r, sb_e.b, sb_e.d, sb_e.c);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input string tag, input logic [3:0] r,
                      input logic b, input logic d, input logic [7:0] cnt);
    exp_t e;
    e.cyc = c; e.tag = tag; e.r = r; e.b = b; e.d = d; e.c = cnt;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] therm(input int k);
    logic [3:0] v;
    v = 4'hF;
    return v << k;
  endfunction

  // Full release expectations given E1, the first edge sampling req_in low.
  task automatic push_seq(input int e1, input string tag, input logic [7:0] cnt);
    int r;
    int t;
    r = e1 + HOLD - 1;
    for (int k = 0; k < 4; k++) begin
      t = r + (k + 1) * GAP;
      push(t - 1, tag, therm(k), 1'b1, 1'b0, cnt);
      push(t, tag, therm(k + 1), (k != 3), (k == 3), cnt);
    end
    push(r + 4 * GAP + 1, tag, 4'h0, 1'b0, 1'b0, cnt);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s drain observed=%0d pending expected=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    int c;
    int e1;
    int r;
    int a;
    rst_n  = 1'b1;
    req_in = 1'b0;
    req2   = 1'b0;
    #1 rst_n = 1'b0;
    #1;

    // Power-on reset values.
    chk("por_rst", rst_out, 4'hF);
    chk("por_busy", busy, 1'b1);
    chk("por_done", done, 1'b0);
    chk("por_cnt", event_cnt, 8'd0);
    chk("por_cnt2", event_cnt2, 2'd0);
    tick();
    tick();
    chk("por_rst_held", rst_out, 4'hF);
    rst_n = 1'b1;
    push_seq(cyc + 1, "por_seq", 8'd0);
    wait_drain("por");

    // Three-cycle request from IDLE.
    tick();
    c = cyc;
    push(c, "req3_idle", 4'h0, 1'b0, 1'b0, 8'd0);
    push(c + 1, "req3_assert", 4'hF, 1'b1, 1'b0, 8'd1);
    push(c + 3, "req3_hold", 4'hF, 1'b1, 1'b0, 8'd1);
    push_seq(c + 4, "req3_seq", 8'd1);
    req_in = 1'b1;
    repeat (3) tick();
    req_in = 1'b0;
    wait_drain("req3");

    // Request held high for 100 cycles: reset stays fully asserted.
    tick();
    c = cyc;
    for (int i = 1; i <= 100; i++) push(c + i, "long_hold", 4'hF, 1'b1, 1'b0, 8'd2);
    push_seq(c + 101, "long_seq", 8'd2);
    req_in = 1'b1;
    repeat (100) tick();
    req_in = 1'b0;
    wait_drain("long");

    // Abort while rst_out = 4'hC.
    tick();
    c = cyc;
    e1 = c + 2;
    r  = e1 + HOLD - 1;
    a  = r + 2 * GAP + 3;
    push(c + 1, "abort_start", 4'hF, 1'b1, 1'b0, 8'd3);
    push(r + GAP, "abort_e", 4'hE, 1'b1, 1'b0, 8'd3);
    push(r + 2 * GAP, "abort_c", 4'hC, 1'b1, 1'b0, 8'd3);
    push(a - 1, "abort_pre", 4'hC, 1'b1, 1'b0, 8'd3);
    push(a, "abort_hit", 4'hF, 1'b1, 1'b0, 8'd4);
    push_seq(a + 1, "abort_seq", 8'd4);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    wait_until(a - 1);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    wait_drain("abort");

    // Rise on the same edge as the scheduled 4'hC -> 4'h8 clear.
    tick();
    c = cyc;
    e1 = c + 2;
    r  = e1 + HOLD - 1;
    a  = r + 3 * GAP;
    push(c + 1, "coll_start", 4'hF, 1'b1, 1'b0, 8'd5);
    push(r + 2 * GAP, "coll_c", 4'hC, 1'b1, 1'b0, 8'd5);
    push(a - 1, "coll_pre", 4'hC, 1'b1, 1'b0, 8'd5);
    push(a, "coll_hit", 4'hF, 1'b1, 1'b0, 8'd6);
    push_seq(a + 1, "coll_seq", 8'd6);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    wait_until(a - 1);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    wait_drain("coll");

    // Saturation with a 2-bit counter, pulses separated by one low cycle.
    for (int i = 1; i <= 5; i++) begin
      req2 = 1'b1;
      tick();
      chk("sat_cnt", event_cnt2, (i < 3) ? i : 3);
      req2 = 1'b0;
      tick();
    end
    repeat (5) tick();
    chk("sat_stay", event_cnt2, 2'd3);

    // Asynchronous reset during RELEASE.
    tick();
    c = cyc;
    e1 = c + 2;
    r  = e1 + HOLD - 1;
    push(c + 1, "arst_start", 4'hF, 1'b1, 1'b0, 8'd7);
    push(r + GAP, "arst_e", 4'hE, 1'b1, 1'b0, 8'd7);
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    wait_until(r + GAP + 2);
    rst_n = 1'b0;
    #1;
    chk("arst_rst", rst_out, 4'hF);
    chk("arst_busy", busy, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_cnt", event_cnt, 8'd0);
    chk("arst_cnt2", event_cnt2, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    push_seq(cyc + 1, "arst_seq", 8'd0);
    wait_drain("arst");

    chk("done_pulses", done_seen, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
